// File: rtl/spi_tx_8lane.sv
`default_nettype none
// ============================================================================
//  Module      : spi_tx_8lane
//  Description : 8-lane SPI transmitter; sends a 128-bit block as 16 bytes,
//                MSB byte first, with a one-entry holding buffer.
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_tx_8lane #(
    parameter int CLK_DIV = 2,
    parameter int CS_GAP  = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [127:0] tx_data,
    input  logic         tx_valid,
    output logic         tx_ready,
    output logic [7:0]   spi_data,
    output logic         spi_clk,
    output logic         spi_cs_n,
    output logic         spi_active,
    output logic         tx_done
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LOW  = 3'd1;
    localparam logic [2:0] S_HIGH = 3'd2;
    localparam logic [2:0] S_HOLD = 3'd3;
    localparam logic [2:0] S_GAP  = 3'd4;

    localparam logic [7:0] c_div_last  = 8'(CLK_DIV - 1);
    localparam logic [7:0] c_gap_last  = 8'(CS_GAP - 1);
    localparam logic [3:0] c_last_byte = 4'd15;

    logic [2:0]   r_state;
    logic [2:0]   w_state_next;
    logic [7:0]   r_phase_cnt;
    logic [3:0]   r_byte_cnt;
    logic         r_buf_full;
    logic [127:0] r_buf;
    logic [119:0] r_shift;
    logic [7:0]   r_spi_data;
    logic         r_tx_done;

    logic w_phase_end;
    logic w_accept;
    logic w_load;
    logic w_next_byte;
    logic w_frame_end;

    always_comb begin
        w_phase_end = 1'b0;
        case (r_state)
            S_LOW, S_HIGH, S_HOLD: w_phase_end = (r_phase_cnt == c_div_last);
            S_GAP:                 w_phase_end = (r_phase_cnt == c_gap_last);
            default:               w_phase_end = 1'b0;
        endcase
    end

    // The buffer is full during the transfer edge, so tx_ready is already low then.
    assign w_accept    = tx_valid && !r_buf_full;
    assign w_load      = r_buf_full &&
                         ((r_state == S_IDLE) || ((r_state == S_GAP) && w_phase_end));
    assign w_next_byte = (r_state == S_HIGH) && w_phase_end && (r_byte_cnt != c_last_byte);
    assign w_frame_end = (r_state == S_HOLD) && w_phase_end;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: if (r_buf_full)  w_state_next = S_LOW;
            S_LOW:  if (w_phase_end) w_state_next = S_HIGH;
            S_HIGH: if (w_phase_end) w_state_next = (r_byte_cnt == c_last_byte) ? S_HOLD : S_LOW;
            S_HOLD: if (w_phase_end) w_state_next = S_GAP;
            S_GAP:  if (w_phase_end) w_state_next = r_buf_full ? S_LOW : S_IDLE;
            default:                 w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        spi_clk    = 1'b0;
        spi_cs_n   = 1'b1;
        spi_active = 1'b1;
        case (r_state)
            S_IDLE:        spi_active = 1'b0;
            S_LOW, S_HOLD: spi_cs_n   = 1'b0;
            S_HIGH: begin
                spi_cs_n = 1'b0;
                spi_clk  = 1'b1;
            end
            default: begin
                spi_cs_n   = 1'b1;
                spi_active = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset || (r_state == S_IDLE) || w_phase_end) begin
            r_phase_cnt <= 8'd0;
        end else begin
            r_phase_cnt <= r_phase_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_buf_full <= 1'b0;
        end else if (w_accept) begin
            r_buf_full <= 1'b1;
        end else if (w_load) begin
            r_buf_full <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_buf <= tx_data;
        end
    end

    // Byte 0 goes straight to the lanes on the load edge; the rest wait in r_shift.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_shift    <= '0;
            r_spi_data <= 8'd0;
            r_byte_cnt <= 4'd0;
            r_tx_done  <= 1'b0;
        end else begin
            r_tx_done <= w_frame_end;
            if (w_load) begin
                r_shift    <= r_buf[119:0];
                r_spi_data <= r_buf[127:120];
                r_byte_cnt <= 4'd0;
            end else if (w_next_byte) begin
                r_shift    <= {r_shift[111:0], 8'h00};
                r_spi_data <= r_shift[119:112];
                r_byte_cnt <= r_byte_cnt + 4'd1;
            end else if (w_frame_end) begin
                r_spi_data <= 8'd0;
            end
        end
    end

    assign tx_ready = !r_buf_full;
    assign spi_data = r_spi_data;
    assign tx_done  = r_tx_done;

endmodule
`default_nettype wire
